nav_controller: RTL and testbench
=================================

# nav_controller

Parametrised navigation state machine: the next generation of the two-level location/activity navigator. It supports a configurable number of keys, locations and activities. It adds back-navigation, a minimum-length transition window and a handshake with the background loader. Its outputs drive the renderer's location/activity select and the loader's start strobe.

## Interface
- NUM_KEYS, 3, width of `keys`; legal range 2..15.
- NUM_LOCATIONS, 2, number of selectable locations; codes 1..NUM_LOCATIONS; legal range 1..min(NUM_KEYS,15).
- NUM_ACTIVITIES, 3, number of activities per location; codes 1..NUM_ACTIVITIES; legal range 1..min(NUM_KEYS,15).
- MIN_LOAD_CYCLES, 4, minimum number of cycles `transition` stays high; legal range >=1.
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- keys  in  NUM_KEYS  raw key levels, 1 = pressed; already synchronised upstream.
- load_done  in  1  loader finished drawing target screen; level or pulse.
- activity_done  in  1  single-cycle pulse from the running activity requesting exit.
- transition  out  1  high while in a LOAD state.
- load_start  out  1  single-cycle pulse on the first cycle of each LOAD state.
- location  out  4  current or target location code; 0 = root.
- activity  out  4  current or target activity code; 0 = location home screen.

## Operation
- Key decode:
  - A one-hot `keys` value with bit j set selects index j+1.
  - All-ones `keys` means BACK.
  - Any other value, including zero, is NONE.
- States, encoded as mode {IDLE, LOAD} plus registered cur_loc/cur_act:
  - ROOT: IDLE with loc=0, act=0.
  - HOME(l): IDLE with loc=l, act=0.
  - ACT(l,a): IDLE with loc=l, act=a.
  - LOAD(tl,ta): waiting to enter the target state.
- Transitions, all taken from IDLE. Every target enters LOAD with the target recorded.
  - ROOT: index i <= NUM_LOCATIONS goes to LOAD(i,0). BACK, NONE and out-of-range indices stay in ROOT.
  - HOME(l): index i <= NUM_ACTIVITIES goes to LOAD(l,i). BACK goes to LOAD(0,0). Everything else stays.
  - ACT(l,a): BACK or activity_done goes to LOAD(l,0). If both occur in the same cycle, the result is the same single transition. One-hot keys are ignored.
- LOAD(tl,ta):
  - `location`/`activity` show tl/ta from the first LOAD cycle.
  - `keys` decode and activity_done are ignored for the whole LOAD.
  - The load_done latch clears on LOAD entry and is set by load_done on any LOAD cycle, including the first.
  - Exit to IDLE(tl,ta) on the clock edge where all three hold: keys==0, the latch or load_done is set, and cycles spent in LOAD >= MIN_LOAD_CYCLES.
  - The cycle counter saturates at MIN_LOAD_CYCLES, so no wrap-around.
- Reset values: mode=IDLE, loc=0, act=0, counter=0, latch=0. Therefore transition=0, load_start=0, location=0, activity=0.
- Reset asserted mid-LOAD aborts to ROOT immediately, with no load_start.
- Unreachable encodings (loc > NUM_LOCATIONS, act > NUM_ACTIVITIES, or loc=0 with act!=0) return to ROOT on the next edge.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Key sampled at edge E means: from E, transition=1, load_start=1 for one cycle, and location/activity show the target.
- Counter behaviour:
  - The counter is 1 during the first LOAD cycle.
  - The exit edge is the first edge, counted from E, at which the counter >= MIN_LOAD_CYCLES and the other two conditions hold.
  - transition is therefore high for exactly MIN_LOAD_CYCLES cycles when keys are released and load_done has already arrived.
- Holding a key through LOAD extends transition until release. The held key is never re-decoded after release. A fresh press is required from the IDLE state.
- A press in the first IDLE cycle after LOAD is decoded normally. There is no dead cycle.

## Test plan
- Reset, then press keys=3'b001 for 1 cycle with load_done high -> location=1, activity=0, load_start pulses once, transition high exactly 4 cycles, then HOME(1).
- In HOME(1), hold keys=3'b100 for 10 cycles with load_done pulsed at cycle 2 -> location=1, activity=3, transition stays high until the cycle after release, and no second load_start.
- In ROOT, press keys=3'b100 (index 3 > NUM_LOCATIONS) and keys=3'b011 -> no state change, transition stays 0.
- In ACT(2,1), assert activity_done and keys=3'b111 in the same cycle -> one LOAD(2,1→0), reaching HOME(2). Then BACK from HOME(2) -> ROOT.
- LOAD with load_done withheld for 20 cycles and keys released -> transition high until the edge after load_done, location/activity held at the target.
- Pull resetn low mid-LOAD, asynchronous to clk -> all outputs 0 immediately. After release, ROOT, and keys=0 causes no action.

Source files
------------

// File: rtl/nav_controller.sv
// Two-level location/activity navigator with back-navigation, a minimum-length
// load window and a handshake with the background loader. All outputs are registered.
module nav_controller #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned NUM_LOCATIONS   = 2,
    parameter int unsigned NUM_ACTIVITIES  = 3,
    parameter int unsigned MIN_LOAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                load_done,
    input  logic                activity_done,
    output logic                transition,
    output logic                load_start,
    output logic [3:0]          location,
    output logic [3:0]          activity
);

    localparam int unsigned CntW = $clog2(MIN_LOAD_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MIN_LOAD_CYCLES);
    localparam logic [3:0] MaxLoc = 4'(NUM_LOCATIONS);
    localparam logic [3:0] MaxAct = 4'(NUM_ACTIVITIES);

    typedef enum logic {
        ModeIdle,
        ModeLoad
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [3:0]      loc_q, loc_d;
    logic [3:0]      act_q, act_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            latch_q, latch_d;
    logic            start_q, start_d;

    logic [3:0] key_idx;
    logic       key_back;
    logic       key_none_pressed;
    logic       loc_hit;
    logic       act_hit;
    logic       state_valid;
    logic       cnt_done;
    logic       enter_load;
    logic [3:0] tgt_loc;
    logic [3:0] tgt_act;

    // Only a strictly one-hot key vector yields an index; everything else is BACK or NONE.
    always_comb begin
        key_idx = '0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (keys[j] && $onehot(keys)) begin
                key_idx = 4'(j + 1);
            end
        end
    end

    assign key_back         = &keys;
    assign key_none_pressed = (keys == '0);
    assign loc_hit          = (key_idx != 4'd0) && (key_idx <= MaxLoc);
    assign act_hit          = (key_idx != 4'd0) && (key_idx <= MaxAct);
    assign cnt_done         = (cnt_q >= CntMax);
    assign state_valid      = (loc_q <= MaxLoc) && (act_q <= MaxAct) &&
                              !((loc_q == 4'd0) && (act_q != 4'd0));

    always_comb begin
        enter_load = 1'b0;
        tgt_loc    = loc_q;
        tgt_act    = act_q;
        if (mode_q == ModeIdle) begin
            if (loc_q == 4'd0) begin
                if (loc_hit) begin
                    enter_load = 1'b1;
                    tgt_loc    = key_idx;
                    tgt_act    = 4'd0;
                end
            end else if (act_q == 4'd0) begin
                if (act_hit) begin
                    enter_load = 1'b1;
                    tgt_act    = key_idx;
                end else if (key_back) begin
                    enter_load = 1'b1;
                    tgt_loc    = 4'd0;
                    tgt_act    = 4'd0;
                end
            end else if (key_back || activity_done) begin
                enter_load = 1'b1;
                tgt_act    = 4'd0;
            end
        end
    end

    always_comb begin
        mode_d  = mode_q;
        loc_d   = loc_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        start_d = 1'b0;
        if (!state_valid) begin
            // Corrupted location/activity pair: recover to root without a load.
            mode_d  = ModeIdle;
            loc_d   = 4'd0;
            act_d   = 4'd0;
            cnt_d   = '0;
            latch_d = 1'b0;
        end else if (mode_q == ModeIdle) begin
            if (enter_load) begin
                mode_d  = ModeLoad;
                loc_d   = tgt_loc;
                act_d   = tgt_act;
                cnt_d   = CntW'(1);
                latch_d = 1'b0;
                start_d = 1'b1;
            end
        end else begin
            // Leaving requires released keys so a held key is never re-decoded.
            if (key_none_pressed && (latch_q || load_done) && cnt_done) begin
                mode_d  = ModeIdle;
                cnt_d   = '0;
                latch_d = 1'b0;
            end else begin
                if (!cnt_done) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                latch_d = latch_q | load_done;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q  <= ModeIdle;
            loc_q   <= 4'd0;
            act_q   <= 4'd0;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            loc_q   <= loc_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            start_q <= start_d;
        end
    end

    assign transition = (mode_q == ModeLoad);
    assign load_start = start_q;
    assign location   = loc_q;
    assign activity   = act_q;

endmodule

// File: tb/tb_nav_controller.sv
// Bench for nav_controller: directed scenarios plus random stimulus, every cycle
// compared against a screen-level reference model.
module tb_nav_controller;

    localparam int NK  = 3;
    localparam int NL  = 2;
    localparam int NA  = 3;
    localparam int MIN = 4;

    logic          clk;
    logic          resetn;
    logic [NK-1:0] keys;
    logic          load_done;
    logic          activity_done;
    logic          transition;
    logic          load_start;
    logic [3:0]    location;
    logic [3:0]    activity;

    int n_checks;
    int n_errors;

    // Reference model: which screen is shown, and the progress of any pending load.
    int m_loc;
    int m_act;
    bit m_loading;
    int m_elapsed;
    bit m_seen;
    bit m_start;

    int trans_cycles;
    int start_pulses;

    nav_controller #(
        .NUM_KEYS       (NK),
        .NUM_LOCATIONS  (NL),
        .NUM_ACTIVITIES (NA),
        .MIN_LOAD_CYCLES(MIN)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .keys         (keys),
        .load_done    (load_done),
        .activity_done(activity_done),
        .transition   (transition),
        .load_start   (load_start),
        .location     (location),
        .activity     (activity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loc = 0; m_act = 0; m_loading = 0; m_elapsed = 0; m_seen = 0; m_start = 0;
    endtask

    task automatic begin_load(input int l, input int a);
        m_loc = l; m_act = a; m_loading = 1; m_elapsed = 1; m_seen = 0; m_start = 1;
    endtask

    task automatic model_step(input logic [NK-1:0] k, input bit ld, input bit ad);
        int idx;
        bit back;
        idx  = 0;
        back = (k == {NK{1'b1}});
        if ($countones(k) == 1) begin
            for (int j = 0; j < NK; j++) if (k[j]) idx = j + 1;
        end
        m_start = 0;
        if (!m_loading) begin
            if (m_loc == 0) begin
                if (idx >= 1 && idx <= NL) begin_load(idx, 0);
            end else if (m_act == 0) begin
                if (idx >= 1 && idx <= NA) begin_load(m_loc, idx);
                else if (back) begin_load(0, 0);
            end else if (back || ad) begin
                begin_load(m_loc, 0);
            end
        end else if (k == 0 && (m_seen || ld) && m_elapsed >= MIN) begin
            m_loading = 0;
        end else begin
            m_elapsed++;
            m_seen = m_seen | ld;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".transition"}, int'(transition), int'(m_loading));
        check({tag, ".load_start"}, int'(load_start), int'(m_start));
        check({tag, ".location"},   int'(location),   m_loc);
        check({tag, ".activity"},   int'(activity),   m_act);
    endtask

    // Called at a falling edge: drive, clock, step the model, compare at the next falling edge.
    task automatic tick(input logic [NK-1:0] k, input bit ld, input bit ad, input string tag);
        keys          = k;
        load_done     = ld;
        activity_done = ad;
        @(posedge clk);
        model_step(k, ld, ad);
        @(negedge clk);
        check_outputs(tag);
        if (transition) trans_cycles++;
        if (load_start) start_pulses++;
    endtask

    task automatic settle(input string tag);
        int n;
        n = 0;
        while (m_loading && n < 30) begin
            tick('0, 1'b1, 1'b0, tag);
            n++;
        end
        check({tag, ".timeout"}, int'(transition), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        keys = '0; load_done = 0; activity_done = 0;
        resetn = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        resetn = 1;

        // Select location 1 with load_done already high: exactly MIN load cycles.
        trans_cycles = 0; start_pulses = 0;
        tick(3'b001, 1'b1, 1'b0, "t1_press");
        repeat (5) tick('0, 1'b1, 1'b0, "t1_load");
        check("t1_trans_cycles", trans_cycles, 4);
        check("t1_start_pulses", start_pulses, 1);
        check("t1_location", int'(location), 1);
        check("t1_activity", int'(activity), 0);

        // Held key stretches the load; no re-decode, one load_start.
        trans_cycles = 0; start_pulses = 0;
        for (int i = 0; i < 10; i++) tick(3'b100, i == 2, 1'b0, "t2_hold");
        tick('0, 1'b0, 1'b0, "t2_release");
        check("t2_trans_cycles", trans_cycles, 10);
        check("t2_start_pulses", start_pulses, 1);
        check("t2_activity", int'(activity), 3);
        tick('0, 1'b0, 1'b0, "t2_idle");

        // Back to home then to root; out-of-range and non-one-hot keys are ignored there.
        tick(3'b111, 1'b0, 1'b0, "t3_back_act");
        settle("t3_settle_a");
        tick(3'b111, 1'b0, 1'b0, "t3_back_home");
        settle("t3_settle_b");
        tick(3'b100, 1'b0, 1'b0, "t3_oor");
        tick(3'b011, 1'b0, 1'b0, "t3_multi");
        check("t3_root_transition", int'(transition), 0);
        check("t3_root_location", int'(location), 0);

        // ACT(2,1): BACK and activity_done together give a single transition to HOME(2).
        tick(3'b010, 1'b0, 1'b0, "t4_loc2");
        settle("t4_settle_a");
        tick(3'b001, 1'b0, 1'b0, "t4_act1");
        settle("t4_settle_b");
        start_pulses = 0;
        tick(3'b111, 1'b0, 1'b1, "t4_both");
        settle("t4_settle_c");
        check("t4_start_pulses", start_pulses, 1);
        check("t4_location", int'(location), 2);
        check("t4_activity", int'(activity), 0);
        tick(3'b111, 1'b0, 1'b0, "t4_back");
        settle("t4_settle_d");
        check("t4_root", int'(location), 0);

        // load_done withheld for 20 cycles.
        tick(3'b001, 1'b0, 1'b0, "t5_press");
        trans_cycles = 0;
        repeat (20) tick('0, 1'b0, 1'b0, "t5_wait");
        check("t5_still_loading", trans_cycles, 20);
        tick('0, 1'b1, 1'b0, "t5_done");
        check("t5_exit", int'(transition), 0);

        // Asynchronous reset in the middle of a load.
        tick(3'b111, 1'b0, 1'b0, "t6_back");
        check("t6_loading", int'(transition), 1);
        #2 resetn = 0;
        #1;
        model_reset();
        check_outputs("t6_async");
        @(negedge clk);
        resetn = 1;
        tick('0, 1'b0, 1'b0, "t6_after");
        tick('0, 1'b1, 1'b0, "t6_idle");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [NK-1:0] k;
            case ($urandom_range(0, 4))
                0, 1:    k = '0;
                2:       k = NK'(1) << $urandom_range(0, NK - 1);
                3:       k = '1;
                default: k = NK'($urandom);
            endcase
            tick(k, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
